// File: rtl/led_serial_tx.sv
// -----------------------------------------------------------------------------
// led_serial_tx
//
// Purpose:
//   Drains 24-bit colour words from a first-word-fall-through FIFO and
//   serialises them MSB-first onto a single-wire LED data line using
//   WS2812-style pulse-width bit coding. A frame is PIXELS words followed
//   by a low latch gap of RST_CYC cycles. If the FIFO runs dry at a word
//   boundary inside a frame, the frame is aborted, the line is held low
//   through the latch gap and a sticky underrun flag is raised.
//
// Configuration macro:
//   LED_TX_GRB_EN  - when defined, each loaded word is reordered from
//                    RGB input order to GRB wire order. Timing is unchanged.
//
// Ports:
//   clk          in   clock
//   rst          in   asynchronous, active-high reset
//   start        in   frame trigger pulse, only sampled while idle
//   fifo_dout    in   [23:0] FIFO head word (FWFT)
//   fifo_valid   in   FIFO head word valid
//   fifo_re      out  pop strobe for the FIFO head, one cycle per word
//   led_do       out  serial LED data line (registered)
//   busy         out  high in every state except IDLE
//   frame_done   out  one-cycle pulse on the last cycle of the latch gap
//   underrun     out  sticky FIFO-empty-at-word-boundary flag
//   state_dbg_o  out  [1:0] current FSM state (IDLE=0 LOAD=1 SEND=2 GAP=3)
//
// FIFO handshake:
//   The FIFO presents fifo_dout with fifo_valid high whenever a word is
//   available. This block pops a word by raising fifo_re in the same cycle
//   it consumes fifo_dout; fifo_re is only ever high while fifo_valid is
//   high, so every pulse is exactly one accepted word.
// -----------------------------------------------------------------------------
module led_serial_tx #(
  parameter int T0H_CYC = 40,
  parameter int T1H_CYC = 80,
  parameter int BIT_CYC = 125,
  parameter int RST_CYC = 30000,
  parameter int PIXELS  = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [23:0] fifo_dout,
  input  logic        fifo_valid,
  output logic        fifo_re,
  output logic        led_do,
  output logic        busy,
  output logic        frame_done,
  output logic        underrun,
  output logic [1:0]  state_dbg_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2,
    GAP  = 2'd3
  } state_t;

  localparam logic [15:0] T0H_W    = 16'(T0H_CYC);
  localparam logic [15:0] T1H_W    = 16'(T1H_CYC);
  localparam logic [15:0] BIT_LAST = 16'(BIT_CYC - 1);
  localparam logic [15:0] RST_LAST = 16'(RST_CYC - 1);
  localparam logic [15:0] PIX_W    = 16'(PIXELS);

  state_t      state_q, state_d;
  logic [23:0] shift_q, shift_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic [15:0] cyc_cnt_q, cyc_cnt_d;
  logic [15:0] pix_cnt_q, pix_cnt_d;
  logic        led_q, led_d;
  logic        underrun_q, underrun_d;

  logic [23:0] load_word;
  logic [15:0] pix_next;
  logic [15:0] high_thr;

  // Byte order presented to the wire.
`ifdef LED_TX_GRB_EN
  assign load_word = {fifo_dout[15:8], fifo_dout[23:16], fifo_dout[7:0]};
`else
  assign load_word = fifo_dout;
`endif

  assign pix_next = pix_cnt_q + 16'd1;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      shift_q    <= 24'd0;
      bit_cnt_q  <= 5'd0;
      cyc_cnt_q  <= 16'd0;
      pix_cnt_q  <= 16'd0;
      led_q      <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      cyc_cnt_q  <= cyc_cnt_d;
      pix_cnt_q  <= pix_cnt_d;
      led_q      <= led_d;
      underrun_q <= underrun_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    cyc_cnt_d  = cyc_cnt_q;
    pix_cnt_d  = pix_cnt_q;
    underrun_d = underrun_q;
    fifo_re    = 1'b0;
    frame_done = 1'b0;
    high_thr   = T0H_W;
    led_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = LOAD;
          underrun_d = 1'b0;
          pix_cnt_d  = 16'd0;
        end
      end

      // First word of a frame: wait as long as it takes for data.
      LOAD: begin
        if (fifo_valid) begin
          fifo_re   = 1'b1;
          shift_d   = load_word;
          bit_cnt_d = 5'd23;
          cyc_cnt_d = 16'd0;
          state_d   = SEND;
        end
      end

      SEND: begin
        if (cyc_cnt_q == BIT_LAST) begin
          cyc_cnt_d = 16'd0;
          if (bit_cnt_q != 5'd0) begin
            shift_d   = {shift_q[22:0], 1'b0};
            bit_cnt_d = bit_cnt_q - 5'd1;
          end else begin
            // Word boundary: finish the frame, chain the next word with
            // no idle cycle, or abort on an empty FIFO.
            pix_cnt_d = pix_next;
            if (pix_next == PIX_W) begin
              state_d = GAP;
            end else if (fifo_valid) begin
              fifo_re   = 1'b1;
              shift_d   = load_word;
              bit_cnt_d = 5'd23;
            end else begin
              underrun_d = 1'b1;
              state_d    = GAP;
            end
          end
        end else begin
          cyc_cnt_d = cyc_cnt_q + 16'd1;
        end
      end

      // Latch gap: cyc_cnt was zeroed on the way in.
      GAP: begin
        if (cyc_cnt_q == RST_LAST) begin
          frame_done = 1'b1;
          cyc_cnt_d  = 16'd0;
          state_d    = IDLE;
        end else begin
          cyc_cnt_d = cyc_cnt_q + 16'd1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // The line register is loaded from the values the bit counters take in
    // the next cycle, so led_do lines up with cyc_cnt_q: the first high
    // cycle of a word is the cycle right after its fifo_re pulse.
    high_thr = shift_d[23] ? T1H_W : T0H_W;
    led_d    = (state_d == SEND) && (cyc_cnt_d < high_thr);
  end

  assign led_do      = led_q;
  assign busy        = (state_q != IDLE);
  assign underrun    = underrun_q;
  assign state_dbg_o = state_q;

endmodule
